// File: rtl/ipsxe_floating_point_z_group_pkg.sv
// Shared definitions for the z*group sequential product path: group width,
// derived-width helpers and the IDLE/MUL/DONE state encoding.
package ipsxe_floating_point_z_group_pkg;

  localparam int GROUP_W = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int z_w(input int man_width, input int rne);
    return man_width + 1 + rne;
  endfunction

  function automatic int ngrp(input int rne1);
    return (rne1 + GROUP_W - 1) / GROUP_W;
  endfunction

  function automatic int acc_w(input int man_width, input int rne, input int rne1);
    return z_w(man_width, rne) + GROUP_W * ngrp(rne1);
  endfunction

  function automatic int out_w(input int man_width, input int rne, input int rne1);
    return z_w(man_width, rne) + rne1 - GROUP_W;
  endfunction

endpackage

// File: rtl/ipsxe_floating_point_z_group_mac_v1_0.sv
// One z x 17-bit group multiply, shifted into position by the group index
// and added to the running accumulator (single APM's worth of logic).
module ipsxe_floating_point_z_group_mac_v1_0
  import ipsxe_floating_point_z_group_pkg::*;
#(
  parameter int Z_W   = 55,
  parameter int ACC_W = 106,
  parameter int CNT_W = 2
) (
  input  logic [ACC_W-1:0]   acc,
  input  logic [Z_W-1:0]     z,
  input  logic [GROUP_W-1:0] grp,
  input  logic [CNT_W-1:0]   cnt,
  output logic [ACC_W-1:0]   acc_next
);

  localparam int PROD_W = Z_W + GROUP_W;

  logic [PROD_W-1:0] prod;
  logic [31:0]       shamt;

  always_comb begin
    prod     = PROD_W'(z) * PROD_W'(grp);
    shamt    = GROUP_W * 32'(cnt);
    acc_next = acc + (ACC_W'(prod) << shamt);
  end

endmodule

// File: rtl/ipsxe_floating_point_z_group_mult_seq_v1_0.sv
// Sequential z*y producer: one 17-bit group of y per clock, LSB group first.
// Optional IPSXE_FLT_Z_GROUP_STICKY_EN folds the dropped low bits into the output LSB.
module ipsxe_floating_point_z_group_mult_seq_v1_0
  import ipsxe_floating_point_z_group_pkg::*;
#(
  parameter  int MAN_WIDTH = 52,
  parameter  int RNE       = 2,
  parameter  int RNE1      = 49,
  localparam int Z_W       = z_w(MAN_WIDTH, RNE),
  localparam int OUT_W     = out_w(MAN_WIDTH, RNE, RNE1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [Z_W-1:0]   i_z,
  input  logic [RNE1-1:0]  i_y,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [OUT_W-1:0] o_z_group_rne1_dlt17zeros
);

  localparam int NGRP  = ngrp(RNE1);
  localparam int ACC_W = acc_w(MAN_WIDTH, RNE, RNE1);
  localparam int CNT_W = (NGRP > 1) ? $clog2(NGRP) : 1;
  localparam int YP_W  = GROUP_W * NGRP;

  state_t           state;
  logic [Z_W-1:0]   z_q;
  logic [YP_W-1:0]  y_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_next;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] res;
  logic             valid_q;

  assign o_ready = (state == IDLE) | ((state == DONE) & i_ready);
  assign o_valid = valid_q;

  // y_q shifts right each MUL cycle so the current group is always its low bits
  ipsxe_floating_point_z_group_mac_v1_0 #(
    .Z_W  (Z_W),
    .ACC_W(ACC_W),
    .CNT_W(CNT_W)
  ) u_mac (
    .acc     (acc),
    .z       (z_q),
    .grp     (y_q[GROUP_W-1:0]),
    .cnt     (cnt),
    .acc_next(acc_next)
  );

`ifdef IPSXE_FLT_Z_GROUP_STICKY_EN
  logic sticky;
  assign o_z_group_rne1_dlt17zeros = {res[OUT_W-1:1], res[0] | sticky};
`else
  assign o_z_group_rne1_dlt17zeros = res;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      z_q     <= '0;
      y_q     <= '0;
      acc     <= '0;
      cnt     <= '0;
      res     <= '0;
      valid_q <= 1'b0;
`ifdef IPSXE_FLT_Z_GROUP_STICKY_EN
      sticky  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            z_q   <= i_z;
            y_q   <= YP_W'(i_y);
            acc   <= '0;
            cnt   <= '0;
            state <= MUL;
          end
        end
        MUL: begin
          acc <= acc_next;
          y_q <= y_q >> GROUP_W;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(NGRP - 1)) begin
            state   <= DONE;
            valid_q <= 1'b1;
            res     <= acc_next[Z_W+RNE1-1:GROUP_W];
`ifdef IPSXE_FLT_Z_GROUP_STICKY_EN
            sticky  <= |acc_next[GROUP_W-1:0];
`endif
          end
        end
        DONE: begin
          if (i_ready) begin
            valid_q <= 1'b0;
            if (i_valid) begin
              z_q   <= i_z;
              y_q   <= YP_W'(i_y);
              acc   <= '0;
              cnt   <= '0;
              state <= MUL;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ipsxe_floating_point_z_group_mult_seq_v1_0.sv
// Self-checking bench: wide-arithmetic reference (z*y)>>17 versus the sequential DUT.
module tb_ipsxe_floating_point_z_group_mult_seq_v1_0;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic [54:0] i_z = '0;
  logic [48:0] i_y = '0;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic [86:0] o_res;

  int checks = 0;
  int errors = 0;

  always #5 i_clk = ~i_clk;

  ipsxe_floating_point_z_group_mult_seq_v1_0 dut (
    .i_clk                    (i_clk),
    .i_rst_n                  (i_rst_n),
    .i_valid                  (i_valid),
    .o_ready                  (o_ready),
    .i_z                      (i_z),
    .i_y                      (i_y),
    .o_valid                  (o_valid),
    .i_ready                  (i_ready),
    .o_z_group_rne1_dlt17zeros(o_res)
  );

  function automatic logic [86:0] model(input logic [54:0] z, input logic [48:0] y);
    logic [127:0] p;
    logic [86:0]  r;
    p = 128'(z) * 128'(y);
    r = p[103:17];
`ifdef IPSXE_FLT_Z_GROUP_STICKY_EN
    if (|p[16:0]) r[0] = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [54:0] rz();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[54:0];
  endfunction

  function automatic logic [48:0] ry();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[48:0];
  endfunction

  task automatic start_op(input logic [54:0] z, input logic [48:0] y);
    @(negedge i_clk);
    i_valid = 1'b1;
    i_z = z;
    i_y = y;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_z = rz();
    i_y = ry();
  endtask

  // Counts edges after the accept edge until o_valid is seen (bounded)
  task automatic wait_result(output int lat);
    lat = 0;
    while (!o_valid && lat < 20) begin
      @(posedge i_clk);
      #1;
      lat++;
      if (lat < 3) begin
        i_z = rz();
        i_y = ry();
      end
    end
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_res !== 87'd0) begin
      errors++;
      $display("FAIL reset: valid=%b ready=%b out=%h, want 0/1/0", o_valid, o_ready, o_res);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  task automatic test_corner();
    logic [86:0] e;
    int lat;
    e = '0;
    e[85] = 1'b1;
    start_op(55'd1 << 54, 49'd1 << 48);
    wait_result(lat);
    checks++;
    if (lat != 3 || o_res !== e) begin
      errors++;
      $display("FAIL corner_msb: lat=%0d out=%h, want lat=3 out=%h", lat, o_res, e);
    end
    consume();
  endtask

  task automatic test_all_ones();
    logic [86:0] e;
    int lat;
    e = model('1, '1);
    start_op('1, '1);
    wait_result(lat);
    checks++;
    if (lat != 3 || o_res !== e) begin
      errors++;
      $display("FAIL all_ones: lat=%0d out=%h, want lat=3 out=%h", lat, o_res, e);
    end
    consume();
  endtask

  task automatic test_one_one();
    logic [86:0] e;
    int lat;
`ifdef IPSXE_FLT_Z_GROUP_STICKY_EN
    e = 87'd1;
`else
    e = 87'd0;
`endif
    start_op(55'd1, 49'd1);
    wait_result(lat);
    checks++;
    if (o_res !== e) begin
      errors++;
      $display("FAIL one_one: out=%h, want %h", o_res, e);
    end
    consume();
  endtask

  task automatic test_random();
    logic [54:0] z;
    logic [48:0] y;
    logic [86:0] e;
    int lat;
    for (int n = 0; n < 1000; n++) begin
      z = rz();
      y = ry();
      if (n % 50 == 0) z = '1;
      if (n % 70 == 1) y = 49'h1_FFFF;
      e = model(z, y);
      start_op(z, y);
      wait_result(lat);
      checks++;
      if (lat != 3 || o_res !== e) begin
        errors++;
        $display("FAIL random[%0d]: lat=%0d out=%h, want lat=3 out=%h", n, lat, o_res, e);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [54:0] z;
    logic [48:0] y;
    logic [86:0] e;
    int lat;
    int bad;
    z = rz();
    y = ry();
    e = model(z, y);
    start_op(z, y);
    wait_result(lat);
    bad = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      i_valid = 1'b1;
      i_z = rz();
      i_y = ry();
      #1;
      checks++;
      if (o_valid !== 1'b1 || o_res !== e || o_ready !== 1'b0) begin
        errors++;
        bad++;
        $display("FAIL backpressure[%0d]: valid=%b ready=%b out=%h, want 1/0/%h",
                 c, o_valid, o_ready, o_res, e);
      end
    end
    @(negedge i_clk);
    i_valid = 1'b0;
    consume();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      if (o_valid !== 1'b0) bad++;
    end
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || bad != 0) begin
      errors++;
      $display("FAIL backpressure_drain: valid=%b ready=%b bad=%0d, want 0/1/0", o_valid, o_ready, bad);
    end
  endtask

  task automatic test_back_to_back();
    logic [86:0] q[$];
    logic [86:0] e;
    logic [54:0] cz;
    logic [48:0] cy;
    int sent, got, last;
    sent = 0;
    got = 0;
    last = -1;
    cz = '0;
    cy = '0;
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 200 && got < 6; cyc++) begin
      @(negedge i_clk);
      if (o_valid) begin
        e = (q.size() > 0) ? q.pop_front() : '0;
        checks++;
        if (o_res !== e || (last >= 0 && cyc - last != 4)) begin
          errors++;
          $display("FAIL back_to_back[%0d]: out=%h gap=%0d, want out=%h gap=4",
                   got, o_res, cyc - last, e);
        end
        last = cyc;
        got++;
      end
      if (sent < 6) begin
        cz = rz();
        cy = ry();
        i_valid = 1'b1;
        i_z = cz;
        i_y = cy;
      end else begin
        i_valid = 1'b0;
      end
      #1;
      if (i_valid && o_ready) begin
        q.push_back(model(cz, cy));
        sent++;
      end
    end
    i_valid = 1'b0;
    i_ready = 1'b0;
    checks++;
    if (got != 6) begin
      errors++;
      $display("FAIL back_to_back_count: got=%0d, want 6", got);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start_op('1, '1);
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_res !== 87'd0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b ready=%b out=%h, want 0/1/0", o_valid, o_ready, o_res);
    end
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_valid: valid cycles=%0d, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_corner();
    test_all_ones();
    test_reset_mid();
    test_one_one();
    test_random();
    test_backpressure();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
